// File: rtl/bram_checker_if.sv
// +--------------------------------------------------------------------------+
// | bram_checker_if: dual-port BRAM command and read-data bundle as seen by  |
// | the read-back checker.                        Revision: 1.0              |
// +--------------------------------------------------------------------------+
`default_nettype none

interface bram_checker_if #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 10
);
  logic                  we_a;
  logic                  we_b;
  logic [ADDR_WIDTH-1:0] addr_a;
  logic [ADDR_WIDTH-1:0] addr_b;
  logic [DATA_WIDTH-1:0] data_a;
  logic [DATA_WIDTH-1:0] data_b;
  logic [DATA_WIDTH-1:0] q_a;
  logic [DATA_WIDTH-1:0] q_b;

  // The BRAM side drives everything; the checker only snoops.
  modport master (
    output we_a, we_b, addr_a, addr_b, data_a, data_b, q_a, q_b
  );

  modport slave (
    input we_a, we_b, addr_a, addr_b, data_a, data_b, q_a, q_b
  );
endinterface

`default_nettype wire

// File: rtl/bram_checker.sv
// +--------------------------------------------------------------------------+
// | bram_checker: scoreboard-based read-back checker for a dual-port BRAM    |
// | with pass/fail/miss counters and first-mismatch capture.  Revision: 1.0  |
// +--------------------------------------------------------------------------+
`default_nettype none

module bram_checker #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 10,
  parameter int ENTRIES    = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  bram_checker_if.slave         bram,
  output logic [7:0]            pass_count,
  output logic [7:0]            fail_count,
  output logic [7:0]            miss_count,
  output logic                  overflow,
  output logic                  err,
  output logic                  err_port,
  output logic [ADDR_WIDTH-1:0] err_addr,
  output logic [DATA_WIDTH-1:0] err_expected,
  output logic [DATA_WIDTH-1:0] err_actual
);

  localparam int IDX_W = (ENTRIES > 1) ? $clog2(ENTRIES) : 1;

  logic [ENTRIES-1:0]    valid_q, valid_d;
  logic [ADDR_WIDTH-1:0] sb_addr_q [ENTRIES];
  logic [ADDR_WIDTH-1:0] sb_addr_d [ENTRIES];
  logic [DATA_WIDTH-1:0] sb_data_q [ENTRIES];
  logic [DATA_WIDTH-1:0] sb_data_d [ENTRIES];

  logic             hit_a, hit_b, free0_ok, free1_ok, a_alloc, b_slot_ok;
  logic [IDX_W-1:0] idx_a, idx_b, free0, free1, b_slot;

  logic                  chk_a_q, chk_a_d, chk_b_q, chk_b_d;
  logic                  hit1_a_q, hit1_a_d, hit1_b_q, hit1_b_d;
  logic [ADDR_WIDTH-1:0] addr1_a_q, addr1_a_d, addr1_b_q, addr1_b_d;
  logic [DATA_WIDTH-1:0] exp1_a_q, exp1_a_d, exp1_b_q, exp1_b_d;

  logic pass_a, pass_b, fail_a, fail_b, miss_a, miss_b;

  logic [7:0]            pass_count_q, pass_count_d;
  logic [7:0]            fail_count_q, fail_count_d;
  logic [7:0]            miss_count_q, miss_count_d;
  logic                  overflow_q, overflow_d;
  logic                  err_q, err_d;
  logic                  err_port_q, err_port_d;
  logic [ADDR_WIDTH-1:0] err_addr_q, err_addr_d;
  logic [DATA_WIDTH-1:0] err_expected_q, err_expected_d;
  logic [DATA_WIDTH-1:0] err_actual_q, err_actual_d;

  function automatic logic [7:0] sat_add(input logic [7:0] cnt, input logic [1:0] inc);
    logic [8:0] sum;
    sum = {1'b0, cnt} + {7'b0, inc};
    return sum[8] ? 8'hff : sum[7:0];
  endfunction

  // Lookups and free-slot search all see the scoreboard as it was before this edge.
  always_comb begin
    hit_a    = 1'b0;
    idx_a    = '0;
    hit_b    = 1'b0;
    idx_b    = '0;
    free0_ok = 1'b0;
    free0    = '0;
    free1_ok = 1'b0;
    free1    = '0;
    for (int i = 0; i < ENTRIES; i++) begin
      if (valid_q[i] && !hit_a && sb_addr_q[i] == bram.addr_a) begin
        hit_a = 1'b1;
        idx_a = IDX_W'(i);
      end
      if (valid_q[i] && !hit_b && sb_addr_q[i] == bram.addr_b) begin
        hit_b = 1'b1;
        idx_b = IDX_W'(i);
      end
      if (!valid_q[i]) begin
        if (!free0_ok) begin
          free0_ok = 1'b1;
          free0    = IDX_W'(i);
        end else if (!free1_ok) begin
          free1_ok = 1'b1;
          free1    = IDX_W'(i);
        end
      end
    end
  end

  always_comb begin
    valid_d    = valid_q;
    sb_addr_d  = sb_addr_q;
    sb_data_d  = sb_data_q;
    overflow_d = overflow_q;
    a_alloc    = 1'b0;

    if (bram.we_a) begin
      if (hit_a) begin
        sb_data_d[idx_a] = bram.data_a;
      end else if (free0_ok) begin
        valid_d[free0]   = 1'b1;
        sb_addr_d[free0] = bram.addr_a;
        sb_data_d[free0] = bram.data_a;
        a_alloc          = 1'b1;
      end else begin
        overflow_d = 1'b1;
      end
    end

    // If port A just claimed the first free slot, port B falls back to the second one.
    b_slot    = a_alloc ? free1 : free0;
    b_slot_ok = a_alloc ? free1_ok : free0_ok;

    // A same-address double write keeps port A's data, as the BRAM does.
    if (bram.we_b && !(bram.we_a && bram.addr_a == bram.addr_b)) begin
      if (hit_b) begin
        sb_data_d[idx_b] = bram.data_b;
      end else if (b_slot_ok) begin
        valid_d[b_slot]   = 1'b1;
        sb_addr_d[b_slot] = bram.addr_b;
        sb_data_d[b_slot] = bram.data_b;
      end else begin
        overflow_d = 1'b1;
      end
    end
  end

  always_comb begin
    chk_a_d   = ~bram.we_a;
    hit1_a_d  = hit_a;
    addr1_a_d = bram.addr_a;
    exp1_a_d  = sb_data_q[idx_a];
    chk_b_d   = ~bram.we_b;
    hit1_b_d  = hit_b;
    addr1_b_d = bram.addr_b;
    exp1_b_d  = sb_data_q[idx_b];
  end

  always_comb begin
    pass_a = chk_a_q & hit1_a_q & (bram.q_a == exp1_a_q);
    fail_a = chk_a_q & hit1_a_q & (bram.q_a != exp1_a_q);
    miss_a = chk_a_q & ~hit1_a_q;
    pass_b = chk_b_q & hit1_b_q & (bram.q_b == exp1_b_q);
    fail_b = chk_b_q & hit1_b_q & (bram.q_b != exp1_b_q);
    miss_b = chk_b_q & ~hit1_b_q;

    pass_count_d = sat_add(pass_count_q, {1'b0, pass_a} + {1'b0, pass_b});
    fail_count_d = sat_add(fail_count_q, {1'b0, fail_a} + {1'b0, fail_b});
    miss_count_d = sat_add(miss_count_q, {1'b0, miss_a} + {1'b0, miss_b});

    err_d          = err_q;
    err_port_d     = err_port_q;
    err_addr_d     = err_addr_q;
    err_expected_d = err_expected_q;
    err_actual_d   = err_actual_q;
    if (!err_q) begin
      if (fail_a) begin
        err_d          = 1'b1;
        err_port_d     = 1'b0;
        err_addr_d     = addr1_a_q;
        err_expected_d = exp1_a_q;
        err_actual_d   = bram.q_a;
      end else if (fail_b) begin
        err_d          = 1'b1;
        err_port_d     = 1'b1;
        err_addr_d     = addr1_b_q;
        err_expected_d = exp1_b_q;
        err_actual_d   = bram.q_b;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q        <= '0;
      chk_a_q        <= 1'b0;
      chk_b_q        <= 1'b0;
      hit1_a_q       <= 1'b0;
      hit1_b_q       <= 1'b0;
      addr1_a_q      <= '0;
      addr1_b_q      <= '0;
      exp1_a_q       <= '0;
      exp1_b_q       <= '0;
      pass_count_q   <= '0;
      fail_count_q   <= '0;
      miss_count_q   <= '0;
      overflow_q     <= 1'b0;
      err_q          <= 1'b0;
      err_port_q     <= 1'b0;
      err_addr_q     <= '0;
      err_expected_q <= '0;
      err_actual_q   <= '0;
    end else begin
      valid_q        <= valid_d;
      chk_a_q        <= chk_a_d;
      chk_b_q        <= chk_b_d;
      hit1_a_q       <= hit1_a_d;
      hit1_b_q       <= hit1_b_d;
      addr1_a_q      <= addr1_a_d;
      addr1_b_q      <= addr1_b_d;
      exp1_a_q       <= exp1_a_d;
      exp1_b_q       <= exp1_b_d;
      pass_count_q   <= pass_count_d;
      fail_count_q   <= fail_count_d;
      miss_count_q   <= miss_count_d;
      overflow_q     <= overflow_d;
      err_q          <= err_d;
      err_port_q     <= err_port_d;
      err_addr_q     <= err_addr_d;
      err_expected_q <= err_expected_d;
      err_actual_q   <= err_actual_d;
    end
  end

  // Entry contents are qualified by valid_q, so they need no reset.
  always_ff @(posedge clk) begin
    sb_addr_q <= sb_addr_d;
    sb_data_q <= sb_data_d;
  end

  assign pass_count   = pass_count_q;
  assign fail_count   = fail_count_q;
  assign miss_count   = miss_count_q;
  assign overflow     = overflow_q;
  assign err          = err_q;
  assign err_port     = err_port_q;
  assign err_addr     = err_addr_q;
  assign err_expected = err_expected_q;
  assign err_actual   = err_actual_q;

endmodule

`default_nettype wire

// File: tb/tb_bram_checker.sv
// +--------------------------------------------------------------------------+
// | tb_bram_checker: directed bench for bram_checker driving a dual-port     |
// | BRAM model with optional port-B read corruption.      Revision: 1.0      |
// +--------------------------------------------------------------------------+
`default_nettype none

module tb_bram_checker;

  localparam int DW = 16;
  localparam int AW = 10;
  localparam logic [AW-1:0] NOP_ADDR = 10'd1023;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  bram_checker_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

  logic [7:0]    pass_count, fail_count, miss_count;
  logic          overflow, err, err_port;
  logic [AW-1:0] err_addr;
  logic [DW-1:0] err_expected, err_actual;

  bram_checker #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .ENTRIES(8)) dut (
    .clk          (clk),
    .reset        (reset),
    .bram         (bus),
    .pass_count   (pass_count),
    .fail_count   (fail_count),
    .miss_count   (miss_count),
    .overflow     (overflow),
    .err          (err),
    .err_port     (err_port),
    .err_addr     (err_addr),
    .err_expected (err_expected),
    .err_actual   (err_actual)
  );

  // Read-old dual-port RAM; port A's write lands last on a same-address collision.
  logic [DW-1:0] mem [1024];
  logic [DW-1:0] mem_q_a, mem_q_b;
  logic          cor_req, cor_q;

  always @(posedge clk) begin
    mem_q_a <= mem[bus.addr_a];
    mem_q_b <= mem[bus.addr_b];
    cor_q   <= cor_req;
    if (bus.we_b) mem[bus.addr_b] <= bus.data_b;
    if (bus.we_a) mem[bus.addr_a] <= bus.data_a;
  end

  assign bus.q_a = mem_q_a;
  assign bus.q_b = cor_q ? 16'h0005 : mem_q_b;

  int tests_run    = 0;
  int tests_failed = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic set_cmd(input logic wa, input logic [AW-1:0] aa, input logic [DW-1:0] da,
                         input logic wb, input logic [AW-1:0] ab, input logic [DW-1:0] db,
                         input logic cor);
    bus.we_a   = wa;
    bus.addr_a = aa;
    bus.data_a = da;
    bus.we_b   = wb;
    bus.addr_b = ab;
    bus.data_b = db;
    cor_req    = cor;
  endtask

  task automatic cmd(input logic wa, input logic [AW-1:0] aa, input logic [DW-1:0] da,
                     input logic wb, input logic [AW-1:0] ab, input logic [DW-1:0] db,
                     input logic cor);
    @(negedge clk);
    set_cmd(wa, aa, da, wb, ab, db, cor);
  endtask

  task automatic wr(input logic [AW-1:0] aa, input logic [DW-1:0] da,
                    input logic [AW-1:0] ab, input logic [DW-1:0] db);
    cmd(1'b1, aa, da, 1'b1, ab, db, 1'b0);
  endtask

  task automatic rd(input logic [AW-1:0] aa, input logic [AW-1:0] ab);
    cmd(1'b0, aa, '0, 1'b0, ab, '0, 1'b0);
  endtask

  // Idle cycles are writes to one parked address so they never generate compares.
  task automatic nop(input int n);
    repeat (n) wr(NOP_ADDR, '0, NOP_ADDR, '0);
  endtask

  task automatic check_all_zero(input string pfx);
    check_eq({pfx, "_pass"},     32'(pass_count),   0);
    check_eq({pfx, "_fail"},     32'(fail_count),   0);
    check_eq({pfx, "_miss"},     32'(miss_count),   0);
    check_eq({pfx, "_overflow"}, 32'(overflow),     0);
    check_eq({pfx, "_err"},      32'(err),          0);
    check_eq({pfx, "_err_port"}, 32'(err_port),     0);
    check_eq({pfx, "_err_addr"}, 32'(err_addr),     0);
    check_eq({pfx, "_err_exp"},  32'(err_expected), 0);
    check_eq({pfx, "_err_act"},  32'(err_actual),   0);
  endtask

  initial begin
    set_cmd(1'b1, NOP_ADDR, '0, 1'b1, NOP_ADDR, '0, 1'b0);
    reset = 1'b1;
    repeat (3) @(negedge clk);
    check_all_zero("init");
    reset = 1'b0;

    // Write then read back on the same ports.
    wr(10'd0, 16'd8, 10'd1, 16'd10);
    rd(10'd0, 10'd1);
    wr(10'd0, 16'd9, 10'd1, 16'd11);
    wr(10'd510, 16'd32, 10'd511, 16'd18);
    rd(10'd0, 10'd0);
    rd(10'd0, 10'd1);
    nop(2);
    check_eq("basic_pass", 32'(pass_count), 6);
    check_eq("basic_fail", 32'(fail_count), 0);
    check_eq("basic_miss", 32'(miss_count), 0);
    check_eq("basic_err",  32'(err),        0);

    // Port B returns 5 instead of 11 for address 1.
    cmd(1'b0, 10'd510, '0, 1'b0, 10'd1, '0, 1'b1);
    nop(2);
    check_eq("cor_pass",     32'(pass_count),   7);
    check_eq("cor_fail",     32'(fail_count),   1);
    check_eq("cor_err",      32'(err),          1);
    check_eq("cor_err_port", 32'(err_port),     1);
    check_eq("cor_err_addr", 32'(err_addr),     1);
    check_eq("cor_err_exp",  32'(err_expected), 11);
    check_eq("cor_err_act",  32'(err_actual),   5);

    // A second mismatch (addr 511, expected 18) must not disturb the capture.
    cmd(1'b0, 10'd511, '0, 1'b0, 10'd511, '0, 1'b1);
    nop(2);
    check_eq("cor2_pass",     32'(pass_count),   8);
    check_eq("cor2_fail",     32'(fail_count),   2);
    check_eq("cor2_err_addr", 32'(err_addr),     1);
    check_eq("cor2_err_exp",  32'(err_expected), 11);
    check_eq("cor2_err_act",  32'(err_actual),   5);

    // Collision: A's data wins; a cross-port read during a write sees the old value.
    wr(10'd4, 16'h1111, 10'd4, 16'h2222);
    rd(10'd4, 10'd4);
    cmd(1'b1, 10'd4, 16'h3333, 1'b0, 10'd4, '0, 1'b0);
    rd(10'd4, 10'd4);
    nop(2);
    check_eq("coll_pass", 32'(pass_count), 13);
    check_eq("coll_fail", 32'(fail_count), 2);

    // Reset for two cycles while a read is in flight.
    rd(10'd0, 10'd0);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    set_cmd(1'b1, NOP_ADDR, '0, 1'b1, NOP_ADDR, '0, 1'b0);
    nop(2);
    check_all_zero("rst");

    // Parked address plus six more fills seven entries; then A takes the last, B overflows.
    wr(10'd100, 16'd100, 10'd101, 16'd101);
    wr(10'd102, 16'd102, 10'd103, 16'd103);
    wr(10'd104, 16'd104, 10'd105, 16'd105);
    nop(2);
    check_eq("cap_no_ovf", 32'(overflow), 0);
    wr(10'd106, 16'd106, 10'd107, 16'd107);
    nop(2);
    check_eq("cap_ovf", 32'(overflow), 1);
    rd(10'd106, 10'd107);
    nop(2);
    check_eq("cap_pass", 32'(pass_count), 1);
    check_eq("cap_miss", 32'(miss_count), 1);
    check_eq("cap_fail", 32'(fail_count), 0);

    // Saturation: reach 254 exactly, then +2 must clamp to 255.
    rd(10'd100, 10'd107);
    repeat (126) rd(10'd100, 10'd101);
    nop(2);
    check_eq("sat_254", 32'(pass_count), 254);
    rd(10'd100, 10'd101);
    nop(2);
    check_eq("sat_255", 32'(pass_count), 255);
    repeat (200) rd(10'd100, 10'd101);
    nop(2);
    check_eq("sat_hold", 32'(pass_count), 255);
    check_eq("sat_miss", 32'(miss_count), 2);
    check_eq("sat_fail", 32'(fail_count), 0);
    check_eq("sat_ovf",  32'(overflow),   1);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule

`default_nettype wire
